// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the EX-stage load/store port
// and a debug/loader requester; core wins by default, debug is forced through after starvation.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int STARVE_LIMIT    = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       core_rd_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] core_rd_addr,
  input  logic                       core_wr_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] core_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] core_wr_word,
  output logic                       core_stall,
  input  logic                       dbg_req,
  input  logic                       dbg_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] dbg_wdata,
  output logic                       dbg_ack,
  output logic [DMEM_WORD_WIDTH-1:0] dbg_rdata,
  output logic                       dmem_en,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] dmem_wdata,
  input  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata
);

  typedef enum logic {IDLE, DBG_RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  state_t                     state, state_next;
  logic [CNT_WIDTH-1:0]       starve_cnt, starve_next;
  logic                       core_req;
  logic                       dbg_grant;
  logic                       core_grant;
  logic                       resp_read;
  logic [DMEM_WORD_WIDTH-1:0] rdata_hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      resp_read  <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      if (dbg_grant)
        resp_read <= ~dbg_we;
      if (state == DBG_RESP && resp_read)
        rdata_hold <= dmem_rdata;
    end
  end

  // Everything is gated by reset so the macro sees no access while reset is high.
  always_comb begin
    core_req    = core_rd_en | core_wr_en;
    dbg_grant   = 1'b0;
    core_grant  = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;
    dmem_en     = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    core_stall  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (dbg_req && (!core_req || starve_cnt == LIMIT)) begin
            dbg_grant   = 1'b1;
            starve_next = '0;
            state_next  = DBG_RESP;
          end else begin
            core_grant = core_req;
            if (dbg_req)
              starve_next = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 1'b1;
            else
              starve_next = '0;
          end
        end
        DBG_RESP: begin
          core_grant  = core_req;
          starve_next = '0;
          state_next  = IDLE;
        end
        default: begin
          state_next  = IDLE;
          starve_next = '0;
        end
      endcase

      if (dbg_grant) begin
        dmem_en    = 1'b1;
        dmem_we    = dbg_we;
        dmem_addr  = dbg_addr;
        dmem_wdata = dbg_we ? dbg_wdata : '0;
        core_stall = core_req;
      end else if (core_grant) begin
        // A simultaneous load+store issues only the store.
        dmem_en    = 1'b1;
        dmem_we    = core_wr_en;
        dmem_addr  = core_wr_en ? core_wr_addr : core_rd_addr;
        dmem_wdata = core_wr_en ? core_wr_word : '0;
      end
    end
  end

  assign dbg_ack   = (state == DBG_RESP);
  assign dbg_rdata = (state == DBG_RESP && resp_read) ? dmem_rdata : rdata_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model with its own memory image.
module tb_dmem_arbiter;

  localparam int AW  = 12;
  localparam int WW  = 16;
  localparam int LIM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          core_rd_en, core_wr_en;
  logic [AW-1:0] core_rd_addr, core_wr_addr;
  logic [WW-1:0] core_wr_word;
  logic          core_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [WW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [WW-1:0] dbg_rdata;
  logic          dmem_en, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [WW-1:0] dmem_wdata;
  logic [WW-1:0] dmem_rdata;

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH(AW),
    .DMEM_WORD_WIDTH(WW),
    .STARVE_LIMIT(LIM),
    .CNT_WIDTH(3)
  ) dut (
    .clock(clock), .reset(reset),
    .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_word(core_wr_word),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [WW-1:0] init_word(int i);
    return (i == 32) ? 16'h1234 : 16'(i * 37 + 5);
  endfunction

  // Synchronous single-port memory macro
  logic [WW-1:0] mem [0:4095];
  logic [WW-1:0] mem_q;
  assign dmem_rdata = mem_q;
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    mem_q = '0;
    forever begin
      @(posedge clock);
      if (dmem_en) begin
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        else         mem_q <= mem[dmem_addr];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [WW-1:0] ref_mem [0:4095];
  int            m_starve;
  bit            m_resp, m_resp_read, m_core_rd;
  logic [WW-1:0] m_resp_data, m_hold, m_core_rd_data;

  // Snapshots of DUT outputs from the last checked cycle
  logic          s_en, s_we, s_stall, s_ack;
  logic [AW-1:0] s_addr;
  logic [WW-1:0] s_rdata;
  bit            last_ack;
  int            req_start;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_starve  = 0;
    m_resp    = 0;
    m_hold    = '0;
    m_core_rd = 0;
  endtask

  task automatic set_core(bit rd, bit wr, logic [AW-1:0] ra, logic [AW-1:0] wa, logic [WW-1:0] wd);
    core_rd_en   = rd;
    core_wr_en   = wr;
    core_rd_addr = ra;
    core_wr_addr = wa;
    core_wr_word = wd;
  endtask

  task automatic set_dbg(bit req, bit we, logic [AW-1:0] a, logic [WW-1:0] wd);
    dbg_req   = req;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = wd;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit            creq, dwin, cwin;
    logic          e_en, e_we, e_stall;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wd, e_rdata;
    @(negedge clock);
    if (core_rd_en && core_wr_en)
      $display("protocol violation at cycle %0d: core_rd_en and core_wr_en both high", cyc);
    creq = core_rd_en || core_wr_en;
    dwin = !m_resp && dbg_req && (!creq || m_starve == LIM);
    cwin = creq && !dwin;
    e_en = 0; e_we = 0; e_stall = 0; e_addr = '0; e_wd = '0;
    if (dwin) begin
      e_en = 1; e_we = dbg_we; e_addr = dbg_addr;
      e_wd = dbg_we ? dbg_wdata : '0;
      e_stall = creq;
    end else if (cwin) begin
      e_en = 1; e_we = core_wr_en;
      e_addr = core_wr_en ? core_wr_addr : core_rd_addr;
      e_wd = core_wr_en ? core_wr_word : '0;
    end
    e_rdata = (m_resp && m_resp_read) ? m_resp_data : m_hold;
    chk("dmem_en", dmem_en, e_en);
    chk("dmem_we", dmem_we, e_we);
    chk("dmem_addr", dmem_addr, e_addr);
    chk("dmem_wdata", dmem_wdata, e_wd);
    chk("core_stall", core_stall, e_stall);
    chk("dbg_ack", dbg_ack, m_resp);
    chk("dbg_rdata", dbg_rdata, e_rdata);
    chk("starve_cnt", dut.starve_cnt, m_starve);
    if (m_core_rd) chk("core_rdata", dmem_rdata, m_core_rd_data);
    s_en = dmem_en; s_we = dmem_we; s_addr = dmem_addr;
    s_stall = core_stall; s_ack = dbg_ack; s_rdata = dbg_rdata;
    last_ack = m_resp;
    @(posedge clock);
    m_core_rd = 0;
    if (cwin && !core_wr_en) begin
      m_core_rd = 1;
      m_core_rd_data = ref_mem[core_rd_addr];
    end
    if (dwin) begin
      m_resp = 1;
      m_resp_read = !dbg_we;
      m_resp_data = ref_mem[dbg_addr];
      m_starve = 0;
    end else if (m_resp) begin
      m_resp = 0;
      if (m_resp_read) m_hold = m_resp_data;
      m_starve = 0;
    end else if (dbg_req) begin
      m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
    end else begin
      m_starve = 0;
    end
    if (e_en && e_we) ref_mem[e_addr] = e_wd;
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    model_reset();
    reset = 1'b1;
    set_core(0, 0, '0, '0, '0);
    set_dbg(0, 0, '0, '0);
    // Inputs active during reset must not reach the macro
    #12;
    set_core(1, 0, 12'h005, '0, '0);
    set_dbg(1, 1, 12'h006, 16'h7777);
    #1;
    chk("rst_dmem_en", dmem_en, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    set_core(0, 0, '0, '0, '0);
    set_dbg(0, 0, '0, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Core-only store then load
    set_core(0, 1, '0, 12'h010, 16'hBEEF);
    step();
    chk("core_st_we", s_we, 1);
    chk("core_st_addr", s_addr, 12'h010);
    set_core(1, 0, 12'h010, '0, '0);
    step();
    chk("core_ld_en", s_en, 1);
    chk("core_ld_we", s_we, 0);
    set_core(0, 0, '0, '0, '0);
    step();
    chk("core_ld_data", dmem_rdata, 16'hBEEF);

    // Debug-only read
    set_dbg(1, 0, 12'h020, '0);
    step();
    chk("dbg_rd_addr", s_addr, 12'h020);
    step();
    chk("dbg_rd_ack", s_ack, 1);
    chk("dbg_rd_data", s_rdata, 16'h1234);
    set_dbg(0, 0, '0, '0);
    step();
    chk("dbg_rd_ack_done", s_ack, 0);

    // Starvation: continuous core loads, debug write forced through on the 5th cycle
    set_core(1, 0, 12'h011, '0, '0);
    set_dbg(1, 1, 12'h030, 16'h5555);
    for (int c = 0; c < 6; c++) begin
      step();
      if (c < 4) chk("starve_denied", s_stall, 0);
      if (c == 4) begin
        chk("starve_grant_stall", s_stall, 1);
        chk("starve_grant_addr", s_addr, 12'h030);
      end
      if (c == 5) begin
        chk("starve_ack", s_ack, 1);
        chk("starve_ack_core", s_addr, 12'h011);
      end
    end
    set_dbg(0, 0, '0, '0);
    set_core(0, 0, '0, '0, '0);
    step();
    chk("starve_mem", mem[12'h030], 16'h5555);

    // Simultaneous start: core wins first, debug next idle cycle
    set_core(0, 1, '0, 12'h012, 16'h0F0F);
    set_dbg(1, 0, 12'h010, '0);
    step();
    chk("simul_core_addr", s_addr, 12'h012);
    set_core(0, 0, '0, '0, '0);
    step();
    chk("simul_dbg_addr", s_addr, 12'h010);
    step();
    chk("simul_ack", s_ack, 1);
    chk("simul_rdata", s_rdata, 16'hBEEF);
    set_dbg(0, 0, '0, '0);
    step();

    // Reset during the ack cycle; the reissued request then completes
    set_dbg(1, 0, 12'h020, '0);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_ack", dbg_ack, 0);
    chk("midrst_en", dmem_en, 0);
    chk("midrst_starve", dut.starve_cnt, 0);
    chk("midrst_rdata", dbg_rdata, 0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    step();
    chk("reissue_addr", s_addr, 12'h020);
    step();
    chk("reissue_ack", s_ack, 1);
    chk("reissue_rdata", s_rdata, 16'h1234);
    set_dbg(0, 0, '0, '0);
    step();

    // Double core request: store wins
    set_core(1, 1, 12'h041, 12'h040, 16'hA5A5);
    step();
    chk("double_we", s_we, 1);
    chk("double_addr", s_addr, 12'h040);
    chk("double_stall", s_stall, 0);
    set_core(0, 0, '0, '0, '0);
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      set_core(kind == 1 || kind == 3, kind == 2, 12'($urandom_range(0, 63)),
               12'($urandom_range(0, 63)), 16'($urandom));
      if (last_ack) begin
        set_dbg(0, 0, '0, '0);
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        set_dbg(1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), 16'($urandom));
        req_start = cyc;
      end
      step();
      if (last_ack) chk("dbg_latency_bound", (cyc - req_start) <= (LIM + 2), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name:
dmem_arbiter

Overview:
- Shares the single-port data memory between the EX-stage load/store port and an external debug/loader requester.
- Core accesses win by default. A starvation counter forces a debug grant after STARVE_LIMIT consecutive losing cycles. While debug holds the port, the core is stalled.
- Sits between the exec stage dmem outputs and the dmem macro; the pipeline stall logic consumes core_stall.

Parameters:
DMEM_ADDR_WIDTH, 12, dmem address width
DMEM_WORD_WIDTH, 16, dmem data width
STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced through (1..2^CNT_WIDTH-1)
CNT_WIDTH, 3, starvation counter width

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
core_rd_en  in  1  EX load request (act_load_dmem)
core_rd_addr  in  DMEM_ADDR_WIDTH  EX load address
core_wr_en  in  1  EX store request (act_store_dmem)
core_wr_addr  in  DMEM_ADDR_WIDTH  EX store address
core_wr_word  in  DMEM_WORD_WIDTH  EX store data
core_stall  out  1  core request not serviced this cycle; hold pipeline
dbg_req  in  1  debug access request, level, held until dbg_ack
dbg_we  in  1  1=write, 0=read; stable while dbg_req=1
dbg_addr  in  DMEM_ADDR_WIDTH  debug address; stable while dbg_req=1
dbg_wdata  in  DMEM_WORD_WIDTH  debug write data; stable while dbg_req=1
dbg_ack  out  1  one-cycle pulse: debug access complete
dbg_rdata  out  DMEM_WORD_WIDTH  debug read data, valid with dbg_ack
dmem_en  out  1  memory access enable
dmem_we  out  1  memory write enable
dmem_addr  out  DMEM_ADDR_WIDTH  memory address
dmem_wdata  out  DMEM_WORD_WIDTH  memory write data
dmem_rdata  in  DMEM_WORD_WIDTH  memory read data, one cycle after a read issue

Behaviour:
- Reset (async): state=IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0. All dmem_* and core_stall are 0 while reset is high.
- core_req = core_rd_en | core_wr_en.
  - If both are high, the write is issued, the read is dropped and core_stall=0. Core must not do this; the bench flags it.
- States: IDLE, DBG_RESP.
- IDLE grant decision, combinational within the cycle:
  - debug wins if dbg_req && (!core_req || starve_cnt == STARVE_LIMIT); otherwise the core wins if core_req.
- Core grant:
  - dmem_en=1, dmem_we=core_wr_en, dmem_addr=wr_addr if write else rd_addr, dmem_wdata=core_wr_word if write else 0, core_stall=0.
  - Core read data arrives on dmem_rdata next cycle. The exec path consumes it; it is not re-registered here.
- Debug grant:
  - dmem_en=1, dmem_we=dbg_we, dmem_addr=dbg_addr, dmem_wdata=dbg_wdata if write else 0.
  - core_stall=core_req.
  - starve_cnt<=0; next state DBG_RESP.
- Debug denied (dbg_req && core wins): starve_cnt<=starve_cnt+1, saturating at STARVE_LIMIT.
- dbg_req low in IDLE: starve_cnt<=0.
- DBG_RESP, exactly one cycle:
  - dbg_ack=1 (registered).
  - dbg_rdata = dmem_rdata (passed through this cycle, registered hold afterwards) on reads; dbg_rdata holds its previous value on writes.
  - dbg_req is ignored this cycle; the requester drops it on dbg_ack.
  - Core is granted normally if core_req, otherwise dmem_en=0.
  - Next state IDLE, with starve_cnt=0.
- Idle cycle (no grants): dmem_en=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, core_stall=0.
- Latency:
  - debug request with no core traffic: grant in the same cycle dbg_req rises, ack next cycle (2 cycles req-to-ack).
  - worst case with continuous core traffic: STARVE_LIMIT+2 cycles.
- Back-to-back debug: after ack, a new dbg_req is seen in IDLE at the earliest one cycle later, so the core gets at least one cycle between debug accesses.
- Reset mid-operation (e.g. in DBG_RESP): immediate return to IDLE; the pending dbg_ack is lost and the requester must reissue.
- Core stall does not change core request signals inside the arbiter; the core holds them stable and re-presents them the following cycle.

Test Plan:
- Core-only: store addr 0x010 data 0xBEEF, then load 0x010 -> dmem_en=1 both cycles, dmem_we=1 then 0, core_stall=0 always, dmem_rdata=0xBEEF cycle after load.
- Debug-only read: dbg_req=1, dbg_we=0, dbg_addr=0x020 (mem holds 0x1234) -> dmem_addr=0x020 in cycle 0, dbg_ack=1 with dbg_rdata=0x1234 in cycle 1, then IDLE.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: core load every cycle, dbg_req write 0x030=0x5555 from cycle 0.
  - Required: debug denied cycles 0-3 with starve_cnt 1..4; debug granted cycle 4 with core_stall=1; dbg_ack in cycle 5 with the core granted; mem[0x030]=0x5555.
- Simultaneous start, idle core afterwards: dbg_req and a core store in the same cycle with starve_cnt=0 -> core wins, starve_cnt=1; debug wins next cycle when the core is idle; ack after that.
- Reset in DBG_RESP: assert reset during the ack cycle -> dbg_ack=0, dmem_en=0, state IDLE, starve_cnt=0 immediately; after release, the reissued dbg_req completes normally.
- Double core request: core_rd_en=core_wr_en=1 addr 0x040 -> write issued (dmem_we=1, addr=wr_addr), core_stall=0, bench reports protocol error.
